// File: rtl/telemetry_framer.sv
// Telemetry framer: periodically (or on trigger) reads NUM_REGS sensor registers and streams
// SYNC0, SYNC1, SEQ, LEN, payload, CHK one byte at a time over the serial_tx handshake.
module telemetry_framer #(
  parameter int          NUM_REGS      = 64,
  parameter logic [7:0]  SYNC0         = 8'hAA,
  parameter logic [7:0]  SYNC1         = 8'h55,
  parameter int          PERIOD_CYCLES = 5_000_000,
  parameter int          TMR_SIZE      = 23,
  parameter int          READ_LAT      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trigger,
  output logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       new_tx,
  input  logic       tx_busy,
  input  logic       tx_block,
  output logic       busy,
  output logic [7:0] seq,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_WAIT, SEND, GAP} state_t;

  localparam logic [8:0] IDX_CHK = 9'(NUM_REGS + 4);

  state_t              state_q, state_d;
  logic [8:0]          idx_q, idx_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          byte_q, byte_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          chk_q, chk_d;
  logic [TMR_SIZE-1:0] timer_q, timer_d;
  logic [1:0]          lat_q, lat_d;

  logic tick, req, tx_ready;

  assign tick     = enable && (timer_q == TMR_SIZE'(PERIOD_CYCLES - 1));
  assign req      = tick || trigger;
  assign tx_ready = !tx_busy && !tx_block;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    seq_d   = seq_q;
    chk_d   = chk_q;
    lat_d   = lat_q;
    new_tx  = 1'b0;
    timer_d = (!enable || tick) ? '0 : timer_q + TMR_SIZE'(1);

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      LOAD: begin
        state_d = SEND;
        if (idx_q == 9'd0) begin
          byte_d = SYNC0;
        end else if (idx_q == 9'd1) begin
          byte_d = SYNC1;
        end else if (idx_q == 9'd2) begin
          byte_d = seq_q;
          chk_d  = chk_q + seq_q;
        end else if (idx_q == 9'd3) begin
          byte_d = 8'(NUM_REGS);
          chk_d  = chk_q + 8'(NUM_REGS);
        end else if (idx_q == IDX_CHK) begin
          // Two's complement makes SEQ+LEN+payload+CHK sum to zero mod 256.
          byte_d = 8'h00 - chk_q;
        end else begin
          addr_d  = 8'(idx_q - 9'd4);
          lat_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == 2'(READ_LAT)) begin
          byte_d  = data;
          chk_d   = chk_q + data;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: begin
        // Strobe is qualified combinationally so it can never overlap busy/block.
        if (tx_ready) begin
          new_tx  = 1'b1;
          state_d = GAP;
          if (idx_q == IDX_CHK) seq_d = seq_q + 8'd1;
        end
      end
      GAP: begin
        if (idx_q == IDX_CHK) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      seq_q   <= '0;
      chk_q   <= '0;
      timer_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign overrun = busy && req;
  assign addr    = addr_q;
  assign tx_data = byte_q;
  assign seq     = seq_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Randomized and directed bench for telemetry_framer against a frame-level reference model.
module tb_telemetry_framer;
  localparam int NR  = 4;
  localparam int PER = 100;

  logic       clk = 1'b0;
  logic       rst, enable, trigger, tx_block, tx_busy, new_tx, busy, overrun;
  logic [7:0] addr, data, tx_data, seq;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  telemetry_framer #(
    .NUM_REGS(NR), .SYNC0(8'hAA), .SYNC1(8'h55),
    .PERIOD_CYCLES(PER), .TMR_SIZE(7), .READ_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
    .addr(addr), .data(data), .tx_data(tx_data), .new_tx(new_tx),
    .tx_busy(tx_busy), .tx_block(tx_block), .busy(busy), .seq(seq),
    .overrun(overrun)
  );

  // Sensor register file: one clock read latency, content addr^0x30.
  always @(posedge clk) data <= addr ^ 8'h30;

  // serial_tx stand-in: busy for 20 clocks after each strobe.
  int sbusy = 0;
  always @(posedge clk) begin
    if (new_tx) sbusy <= 20;
    else if (sbusy != 0) sbusy <= sbusy - 1;
  end
  always_comb tx_busy = (sbusy != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: frame-level expectations derived from the framing rules.
  logic [7:0] exq[$];
  logic [7:0] got[$];
  int         m_state = 0;  // 0 idle, 1 frame in flight, 2 gap after checksum
  logic [7:0] m_seq = 8'h00;
  int         m_tmr = 0;
  logic       prev_new = 1'b0;
  int         n_ovr = 0, n_frames = 0;

  always @(negedge clk) begin
    logic       req;
    int         st0;
    logic [7:0] e, s, d;
    if (rst) begin
      exq.delete();
      m_state  = 0;
      m_seq    = 8'h00;
      m_tmr    = 0;
      prev_new = 1'b0;
    end else begin
      st0 = m_state;
      req = trigger || (enable && m_tmr == PER - 1);
      chk("busy", busy, st0 != 0);
      chk("overrun", overrun, (st0 != 0) && req);
      chk("seq", seq, m_seq);
      if (overrun) n_ovr++;
      if (new_tx) begin
        chk("new_tx_legal", {prev_new, tx_busy, tx_block}, 3'b000);
        got.push_back(tx_data);
        if (exq.size() == 0) chk("stray_byte", 1, 0);
        else begin
          e = exq.pop_front();
          chk("tx_byte", tx_data, e);
          if (exq.size() == 0) begin
            m_seq++;
            m_state = 2;
            n_frames++;
          end
        end
      end else if (st0 == 2) m_state = 0;
      if (st0 == 0 && req) begin
        m_state = 1;
        exq.push_back(8'hAA);
        exq.push_back(8'h55);
        exq.push_back(m_seq);
        exq.push_back(8'(NR));
        s = m_seq + 8'(NR);
        for (int i = 0; i < NR; i++) begin
          d = 8'(i) ^ 8'h30;
          exq.push_back(d);
          s = s + d;
        end
        exq.push_back(8'h00 - s);
      end
      m_tmr    = !enable ? 0 : (m_tmr == PER - 1 ? 0 : m_tmr + 1);
      prev_new = new_tx;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while (m_state != 0 && k < max);
    if (k >= max) chk("wait_idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_bytes(input int n, input int max);
    int k = 0;
    while (got.size() < n && k < max) begin @(negedge clk); #1; k++; end
    if (k >= max) chk("wait_bytes_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  logic [7:0] exp1 [9] = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h30, 8'h31, 8'h32, 8'h33, 8'h36};

  initial begin
    int f0, o0, g0, k;
    rst = 1'b1; enable = 1'b0; trigger = 1'b0; tx_block = 1'b0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_seq", seq, 0);
    chk("rst_new_tx", new_tx, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", addr, 0);
    chk("rst_tx_data", tx_data, 0);
    cyc(1);

    // 1: single triggered frame
    got.delete();
    pulse_trig();
    wait_idle(1000);
    chk("t1_len", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t1_byte", got[i], exp1[i]);
    chk("t1_seq", seq, 1);
    chk("t1_busy", busy, 0);

    // 2: periodic frames
    do_reset();
    got.delete();
    f0 = n_frames;
    enable = 1'b1;
    k = 0;
    while (n_frames < f0 + 3 && k < 3000) begin cyc(1); k++; end
    if (k >= 3000) chk("t2_timeout", 1, 0);
    enable = 1'b0;
    wait_idle(1000);
    if (got.size() >= 27) begin
      chk("t2_seq0", got[2], 8'h00);  chk("t2_chk0", got[8], 8'h36);
      chk("t2_seq1", got[11], 8'h01); chk("t2_chk1", got[17], 8'h35);
      chk("t2_seq2", got[20], 8'h02); chk("t2_chk2", got[26], 8'h34);
    end else chk("t2_len", got.size(), 27);

    // 3: trigger mid-frame is dropped
    cyc(30);
    got.delete();
    o0 = n_ovr; f0 = n_frames;
    pulse_trig();
    wait_bytes(4, 1000);
    pulse_trig();
    wait_idle(1000);
    cyc(300);
    chk("t3_overruns", n_ovr - o0, 1);
    chk("t3_frames", n_frames - f0, 1);
    chk("t3_len", got.size(), 9);

    // 4: flow-control block before byte 3
    cyc(30);
    got.delete();
    pulse_trig();
    wait_bytes(3, 1000);
    tx_block = 1'b1;
    g0 = got.size();
    cyc(50);
    chk("t4_no_tx_in_block", got.size(), g0);
    tx_block = 1'b0;
    wait_idle(1000);
    chk("t4_len", got.size(), 9);
    if (got.size() > 3) chk("t4_len_byte", got[3], 8'h04);

    // 5: reset mid-frame
    cyc(30);
    got.delete();
    pulse_trig();
    wait_bytes(5, 1000);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_new_tx", new_tx, 0);
    chk("t5_busy", busy, 0);
    chk("t5_seq", seq, 0);
    cyc(30);
    got.delete();
    pulse_trig();
    wait_idle(1000);
    chk("t5_len", got.size(), 9);
    if (got.size() == 9) begin
      chk("t5_seqbyte", got[2], 8'h00);
      chk("t5_chk", got[8], 8'h36);
    end

    // random traffic: triggers, flow control and enable changes
    for (int c = 0; c < 4000; c++) begin
      trigger = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) tx_block = ~tx_block;
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      cyc(1);
    end
    trigger = 1'b0; tx_block = 1'b0; enable = 1'b0;
    wait_idle(2000);

    // 6: sequence wrap
    do_reset();
    for (int f = 0; f < 255; f++) begin
      pulse_trig();
      wait_idle(1000);
    end
    chk("t6_seq_pre", seq, 8'hFF);
    got.delete();
    pulse_trig();
    wait_idle(1000);
    if (got.size() == 9) begin
      chk("t6_seqbyte", got[2], 8'hFF);
      chk("t6_chk", got[8], 8'h37);
    end else chk("t6_len", got.size(), 9);
    got.delete();
    pulse_trig();
    wait_idle(1000);
    if (got.size() == 9) chk("t6_wrap_seqbyte", got[2], 8'h00);
    else chk("t6_wrap_len", got.size(), 9);
    chk("t6_seq_post", seq, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
